// File: rtl/padovan_sequencer.sv
// Control sequencer that walks the 8-register / dual-mux / ALU datapath through the Padovan recurrence.
// Optional build macro PADSEQ_STEP_EN adds a 'step' input that gates every advance of the compute states.
module padovan_sequencer #(
    parameter int DATAWIDTH     = 8,
    parameter int CNTW          = 8,
    parameter int SELECTIONDECO = 3,
    parameter int SELECTIONALU  = 3,
    parameter logic [SELECTIONALU-1:0]  OP_ADD   = 3'd0,
    parameter logic [SELECTIONALU-1:0]  OP_PASSA = 3'd7,
    parameter logic [SELECTIONDECO-1:0] IDLE_WR  = 3'd7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CNTW-1:0]          nTerms,
    input  logic                     sCarry,
    input  logic [DATAWIDTH-1:0]     sDataInBusC,
`ifdef PADSEQ_STEP_EN
    input  logic                     step,
`endif
    output logic [SELECTIONDECO-1:0] sSelDecoA,
    output logic [SELECTIONDECO-1:0] sSelDecoB,
    output logic [SELECTIONDECO-1:0] sSelDecoC,
    output logic [SELECTIONALU-1:0]  sSelAlu,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [DATAWIDTH-1:0]     result
);

    typedef enum logic [3:0] {
        IDLE, INIT0, INIT1, INIT2, ADD, SH0, SH1, SH2, DONE, ERR
    } seqState_t;

    // Register roles: R0..R2 hold the sliding window P(k-3)..P(k-1), R3 is scratch, R6 holds constant 1.
    localparam logic [SELECTIONDECO-1:0] REG_K3  = SELECTIONDECO'(0);
    localparam logic [SELECTIONDECO-1:0] REG_K2  = SELECTIONDECO'(1);
    localparam logic [SELECTIONDECO-1:0] REG_K1  = SELECTIONDECO'(2);
    localparam logic [SELECTIONDECO-1:0] REG_SCR = SELECTIONDECO'(3);
    localparam logic [SELECTIONDECO-1:0] REG_ONE = SELECTIONDECO'(6);

    seqState_t                state;
    seqState_t                stateNext;
    logic [CNTW-1:0]          cnt;
    logic [SELECTIONDECO-1:0] wrSel;
    logic                     adv;

`ifdef PADSEQ_STEP_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = INIT0;
            INIT0:   if (adv) stateNext = INIT1;
            INIT1:   if (adv) stateNext = INIT2;
            INIT2:   if (adv) stateNext = (cnt == '0) ? DONE : ADD;
            ADD:     if (adv) stateNext = sCarry ? ERR : SH0;
            SH0:     if (adv) stateNext = SH1;
            SH1:     if (adv) stateNext = SH2;
            SH2:     if (adv) stateNext = (cnt == CNTW'(1)) ? DONE : ADD;
            DONE:    stateNext = IDLE;
            ERR:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Write select is suppressed while a step-gated state is holding, so the datapath never sees repeated writes.
    always_comb begin
        sSelDecoA = '0;
        sSelDecoB = '0;
        sSelAlu   = OP_PASSA;
        wrSel     = IDLE_WR;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: busy = 1'b0;
            INIT0: begin
                sSelDecoA = REG_ONE;
                wrSel     = REG_K3;
            end
            INIT1: begin
                sSelDecoA = REG_ONE;
                wrSel     = REG_K2;
            end
            INIT2: begin
                sSelDecoA = REG_ONE;
                wrSel     = REG_K1;
            end
            ADD: begin
                sSelDecoA = REG_K3;
                sSelDecoB = REG_K2;
                sSelAlu   = OP_ADD;
                wrSel     = sCarry ? IDLE_WR : REG_SCR;
            end
            SH0: begin
                sSelDecoA = REG_K2;
                wrSel     = REG_K3;
            end
            SH1: begin
                sSelDecoA = REG_K1;
                wrSel     = REG_K2;
            end
            SH2: begin
                sSelDecoA = REG_SCR;
                wrSel     = REG_K1;
            end
            DONE, ERR: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
        sSelDecoC = adv ? wrSel : IDLE_WR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            result <= '0;
            error  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= (nTerms > CNTW'(2)) ? nTerms - CNTW'(2) : '0;
                        error <= 1'b0;
                    end
                end
                INIT2: if (adv) result <= sDataInBusC;
                ADD: begin
                    if (adv) begin
                        if (sCarry) error  <= 1'b1;
                        else        result <= sDataInBusC;
                    end
                end
                SH2: if (adv) cnt <= cnt - CNTW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_padovan_sequencer.sv
// Directed bench for padovan_sequencer driving a behavioural 8-register / mux / ALU datapath.
// With PADSEQ_STEP_EN defined it also exercises the step-gated advance.
module tb_padovan_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] nTerms = '0;
    logic       sCarry;
    logic [7:0] sDataInBusC;
    logic       step = 1'b1;
    logic [2:0] sSelDecoA, sSelDecoB, sSelDecoC, sSelAlu;
    logic       busy, done, error;
    logic [7:0] result;

    int nChecks = 0;
    int nPass   = 0;

    logic [7:0] rf [6];
    logic [7:0] busA, busB;
    logic [8:0] sum;

    always #5 clk = ~clk;

    padovan_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .nTerms     (nTerms),
        .sCarry     (sCarry),
        .sDataInBusC(sDataInBusC),
`ifdef PADSEQ_STEP_EN
        .step       (step),
`endif
        .sSelDecoA  (sSelDecoA),
        .sSelDecoB  (sSelDecoB),
        .sSelDecoC  (sSelDecoC),
        .sSelAlu    (sSelAlu),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .result     (result)
    );

    // Datapath: R6 reads as constant 1, R7 as 0; only R0..R5 are writable.
    always_comb begin
        busA = (sSelDecoA == 3'd6) ? 8'd1 : (sSelDecoA == 3'd7) ? 8'd0 : rf[sSelDecoA];
        busB = (sSelDecoB == 3'd6) ? 8'd1 : (sSelDecoB == 3'd7) ? 8'd0 : rf[sSelDecoB];
        sum  = {1'b0, busA} + {1'b0, busB};
        if (sSelAlu == 3'd0) begin
            sDataInBusC = sum[7:0];
            sCarry      = sum[8];
        end else begin
            sDataInBusC = busA;
            sCarry      = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (sSelDecoC < 3'd6) rf[sSelDecoC] <= sDataInBusC;
    end

    task automatic checkVal(input string tag, input int got, input int exp);
        nChecks++;
        if (got == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues start, waits for done (bounded), checks latency, busy span, result and error.
    task automatic runTerm(input int n, input int expCycle, input int expRes, input int expErr, input int rePulse);
        int cycle;
        int busyCnt;
        nTerms = 8'(n);
        start  = 1'b1;
        tick();
        start   = 1'b0;
        cycle   = 1;
        busyCnt = 0;
        checkVal($sformatf("n%0d err cleared", n), int'(error), 0);
        while (!done && cycle < 400) begin
            busyCnt += int'(busy);
            if (cycle == rePulse) begin
                start  = 1'b1;
                nTerms = 8'd3;
            end else begin
                start = 1'b0;
            end
            tick();
            cycle++;
        end
        start = 1'b0;
        checkVal($sformatf("n%0d done cycle", n), cycle, expCycle);
        checkVal($sformatf("n%0d busy cycles", n), busyCnt, expCycle - 1);
        checkVal($sformatf("n%0d busy at done", n), int'(busy), 0);
        checkVal($sformatf("n%0d result", n), int'(result), expRes);
        checkVal($sformatf("n%0d error", n), int'(error), expErr);
        tick();
        checkVal($sformatf("n%0d done pulse width", n), int'(done), 0);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        checkVal("rst selA", int'(sSelDecoA), 0);
        checkVal("rst selB", int'(sSelDecoB), 0);
        checkVal("rst selC", int'(sSelDecoC), 7);
        checkVal("rst alu", int'(sSelAlu), 7);
        checkVal("rst busy", int'(busy), 0);
        checkVal("rst done", int'(done), 0);
        checkVal("rst error", int'(error), 0);
        checkVal("rst result", int'(result), 0);
        rst = 1'b0;
        tick();

        runTerm(0, 4, 1, 0, -1);
        runTerm(2, 4, 1, 0, -1);
        runTerm(3, 8, 2, 0, -1);
        runTerm(14, 52, 37, 0, -1);
        checkVal("n14 R0", int'(rf[0]), 21);
        checkVal("n14 R1", int'(rf[1]), 28);
        checkVal("n14 R2", int'(rf[2]), 37);
        runTerm(20, 76, 200, 0, -1);
        runTerm(21, 77, 200, 1, -1);
        checkVal("n21 R3 not written", int'(rf[3]), 200);
        checkVal("n21 R2", int'(rf[2]), 200);
        checkVal("n21 error sticky", int'(error), 1);
        runTerm(10, 36, 12, 0, 5);

        // Asynchronous reset in the middle of a run.
        nTerms = 8'd20;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        checkVal("midrun busy before rst", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        checkVal("midrun rst busy", int'(busy), 0);
        checkVal("midrun rst selC", int'(sSelDecoC), 7);
        checkVal("midrun rst selA", int'(sSelDecoA), 0);
        checkVal("midrun rst result", int'(result), 0);
        tick();
        rst = 1'b0;
        tick();
        runTerm(5, 16, 3, 0, -1);

`ifdef PADSEQ_STEP_EN
        begin
            int expA [7] = '{6, 6, 6, 0, 1, 2, 3};
            int expC [7] = '{0, 1, 2, 3, 0, 1, 2};
            nTerms = 8'd3;
            start  = 1'b1;
            step   = 1'b0;
            tick();
            start = 1'b0;
            for (int p = 0; p < 7; p++) begin
                step = 1'b0;
                tick();
                checkVal($sformatf("step hold%0d selA", p), int'(sSelDecoA), expA[p]);
                checkVal($sformatf("step hold%0d selC", p), int'(sSelDecoC), 7);
                tick();
                checkVal($sformatf("step hold%0d busy", p), int'(busy), 1);
                step = 1'b1;
                #1;
                checkVal($sformatf("step pulse%0d selC", p), int'(sSelDecoC), expC[p]);
                tick();
            end
            step = 1'b1;
            checkVal("step done", int'(done), 1);
            checkVal("step result", int'(result), 2);
            tick();
        end
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
